// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared slice width, FSM state type and slice-count helper for the serial adder.
package serial_add_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// rtl/serial_add_sequencer_if.sv - request/response bundle of the serial adder.
// SERIAL_ADD_SEQ_SUB_EN adds the req_sub request bit.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
`ifdef SERIAL_ADD_SEQ_SUB_EN
  logic             req_sub;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_carry;
  logic             busy;

`ifdef SERIAL_ADD_SEQ_SUB_EN
  modport master (
    output req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_carry, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_carry, busy
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_carry, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_carry, busy
  );
`endif

endinterface

// File: rtl/add_slice_8bit.sv
// rtl/add_slice_8bit.sv - combinational 8-bit a + b + cin slice shared by every cycle of the sequencer.
module add_slice_8bit
  import serial_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - adds two WIDTH-bit operands one 8-bit slice per cycle.
// SERIAL_ADD_SEQ_SUB_EN enables subtraction via req_sub.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  serial_add_sequencer_if.slave bus
);

  localparam int N  = nslice(WIDTH);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("serial_add_sequencer: WIDTH must be a positive multiple of 8");
  end

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q, rsp_carry_q;
  logic               sub_q;
  logic               req_ready_c, rsp_valid_c, busy_c;
  logic               accept, last_slice, first_carry;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout;

`ifdef SERIAL_ADD_SEQ_SUB_EN
  logic req_sub_in;
  assign req_sub_in = bus.req_sub;
`else
  logic req_sub_in;
  assign req_sub_in = 1'b0;
`endif

  assign accept      = (state_q == IDLE) && bus.req_valid;
  assign last_slice  = (k_q == KW'(N - 1));
  // Subtraction is A + ~B + 1, so the incoming carry is forced high.
  assign first_carry = req_sub_in ? 1'b1 : bus.req_cin;

  assign slice_a = a_q[k_q*SLICE_W +: SLICE_W];
  assign slice_b = sub_q ? ~b_q[k_q*SLICE_W +: SLICE_W] : b_q[k_q*SLICE_W +: SLICE_W];

  add_slice_8bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_d = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_slice) state_d = RESP;
      end
      RESP: begin
        busy_c      = 1'b1;
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Upper slices of sum_q keep stale data until the current op overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      rsp_carry_q <= 1'b0;
      sub_q       <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= bus.req_a;
        b_q     <= bus.req_b;
        sub_q   <= req_sub_in;
        carry_q <= first_carry;
        k_q     <= '0;
      end
      if (state_q == RUN) begin
        sum_q[k_q*SLICE_W +: SLICE_W] <= slice_sum;
        carry_q                       <= slice_cout;
        if (last_slice) rsp_carry_q <= slice_cout;
        else            k_q         <= k_q + 1'b1;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.busy      = busy_c;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - directed table-driven bench for serial_add_sequencer (WIDTH=32).
// Subtraction vectors are included when SERIAL_ADD_SEQ_SUB_EN is defined.
module tb_serial_add_sequencer;

  localparam int W = 32;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] exp_sum;
    logic        exp_carry;
    int          hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failures = 0;
  int   rsp_count = 0;
  vec_t vecs[$];

  serial_add_sequencer_if #(.WIDTH(W)) bus ();

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) rsp_count <= rsp_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    bus.req_a   = a;
    bus.req_b   = b;
    bus.req_cin = cin;
`ifdef SERIAL_ADD_SEQ_SUB_EN
    bus.req_sub = sub;
`else
    if (sub) $display("note: sub requested in add-only build");
`endif
  endtask

  // Called at the negedge following the accept edge; returns cycles until rsp_valid.
  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!bus.rsp_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_op(input vec_t v);
    int cyc;
    @(negedge clk);
    check({v.name, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    drive_req(v.a, v.b, v.cin, v.sub);
    @(negedge clk);
    bus.req_valid = 1'b0;
    drive_req(~v.a, ~v.b, ~v.cin, ~v.sub);
    check({v.name, " busy"}, 32'(bus.busy), 32'd1);
    wait_rsp(cyc);
    check({v.name, " latency"}, 32'(cyc), 32'd4);
    check({v.name, " sum"}, bus.rsp_sum, v.exp_sum);
    check({v.name, " carry"}, 32'(bus.rsp_carry), 32'(v.exp_carry));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check({v.name, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
      check({v.name, " hold sum"}, bus.rsp_sum, v.exp_sum);
      check({v.name, " hold carry"}, 32'(bus.rsp_carry), 32'(v.exp_carry));
      check({v.name, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({v.name, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
    check({v.name, " back to idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int   cyc;
    int   base;
    vec_t r;

    vecs.push_back('{"one_plus_two", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 0});
    vecs.push_back('{"wrap_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{"hold_five", 32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 5});
    vecs.push_back('{"mixed", 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 0});
    vecs.push_back('{"top_carry", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{"max_cin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 0});
    vecs.push_back('{"cin_only", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 0});
    vecs.push_back('{"slice0_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 0});
`ifdef SERIAL_ADD_SEQ_SUB_EN
    vecs.push_back('{"sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 0});
    vecs.push_back('{"sub_ok", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 0});
    vecs.push_back('{"sub_cin_ignored", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 0});
`endif

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    drive_req(32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset sum", bus.rsp_sum, 32'h0);
    check("reset carry", 32'(bus.rsp_carry), 32'd0);

    // Idle with req_valid low and a stray rsp_ready must not move the FSM.
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("idle stray rsp_ready", 32'(bus.req_ready), 32'd1);
    check("idle no busy", 32'(bus.busy), 32'd0);
    check("idle no rsp", 32'(bus.rsp_valid), 32'd0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset during the second RUN cycle aborts the op.
    @(negedge clk);
    bus.req_valid = 1'b1;
    drive_req(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort req_ready", 32'(bus.req_ready), 32'd1);
    check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort sum", bus.rsp_sum, 32'h0);
    repeat (6) @(negedge clk);
    check("abort no late rsp", 32'(bus.rsp_valid), 32'd0);
    r = '{"after_abort", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 0};
    run_op(r);

    // Back-to-back: req_valid held high across two ops.
    base = rsp_count;
    @(negedge clk);
    bus.req_valid = 1'b1;
    drive_req(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0);
    @(negedge clk);
    drive_req(32'hA5A5_0000, 32'h0000_5A5A, 1'b1, 1'b0);
    check("b2b busy first", 32'(bus.busy), 32'd1);
    check("b2b no accept in run", 32'(bus.req_ready), 32'd0);
    wait_rsp(cyc);
    check("b2b first latency", 32'(cyc), 32'd4);
    check("b2b first sum", bus.rsp_sum, 32'h0000_1234);
    check("b2b first req_ready", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("b2b idle after handshake", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b second accepted", 32'(bus.busy), 32'd1);
    wait_rsp(cyc);
    check("b2b second latency", 32'(cyc), 32'd4);
    check("b2b second sum", bus.rsp_sum, 32'hA5A5_5A5B);
    check("b2b second carry", 32'(bus.rsp_carry), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b response count", 32'(rsp_count - base), 32'd2);
    check("b2b final idle", 32'(bus.req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
